// File: rtl/uart_sort_host.sv
// Host-side self-test driver for the UART sort engine: streams LFSR-generated
// sequences out byte-wise, then checks returned sequences for order and sum.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_LOAD    | fetch next LFSR word, accumulate tx sum
//   S_SEND    | issue tx_start for current byte once transmitter is free
//   S_WAIT_HI | wait for transmitter to take the byte
//   S_WAIT_LO | wait for transmitter to finish, pick next byte/word/terminator
//   S_END     | issue tx_start for the terminator byte
//   S_FIN     | everything sent, wait for the result stream to complete
module uart_sort_host #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 8,
  parameter int          NUM_SEQ  = 10,
  parameter logic [7:0]  END_BYTE = 8'h0A,
  parameter logic [31:0] SEED     = 32'hACE1_1234
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic [7:0]                     tx_byte,
  output logic                           tx_start,
  input  logic                           tx_busy,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(NUM_SEQ+1)-1:0]   err_count
);

  localparam int NB = WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int SW = WIDTH + $clog2(DEPTH);
  localparam int EW = $clog2(NUM_SEQ + 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
  localparam logic [WW-1:0] W_LAST = WW'(DEPTH - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(NUM_SEQ - 1);
  localparam logic [31:0]   TAPS   = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_END, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       lfsr;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     byte_idx;
  logic [WW-1:0]     word_idx;
  logic [QW-1:0]     tx_seq;
  logic              term_sent;
  logic [SW-1:0]     tx_sum [NUM_SEQ];

  logic [WIDTH-1:0]  rx_shift, prev_word, rx_word;
  logic [BW-1:0]     rx_bidx;
  logic [WW-1:0]     rx_widx;
  logic [QW-1:0]     rx_seq;
  logic [SW-1:0]     rx_sum, sum_now;
  logic              seq_bad, bad_now;

  logic start_acc, rx_take, word_end, seq_end, seq_fail, rx_finish, tx_fire;
  logic byte_last, word_last, seq_last;
  logic [31:0] lfsr_step;

  always_comb begin
    start_acc = start & ~busy;
    rx_take   = rx_valid & busy;
    rx_word   = (rx_shift << 8) | WIDTH'(rx_byte);
    word_end  = rx_take && (rx_bidx == B_LAST);
    seq_end   = word_end && (rx_widx == W_LAST);
    bad_now   = seq_bad || ((rx_widx != '0) && (rx_word < prev_word));
    sum_now   = rx_sum + SW'(rx_word);
    seq_fail  = bad_now || (sum_now != tx_sum[rx_seq]);
    rx_finish = seq_end && (rx_seq == Q_LAST);
    tx_fire   = ((state == S_SEND) || (state == S_END)) && !tx_busy && !rx_finish;
    byte_last = (byte_idx == B_LAST);
    word_last = (word_idx == W_LAST);
    seq_last  = (tx_seq == Q_LAST);
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_acc) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_SEND;
      S_SEND:    if (!tx_busy) state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (tx_busy) state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (term_sent)                  state_nxt = S_FIN;
          else if (!byte_last)            state_nxt = S_SEND;
          else if (!(word_last && seq_last)) state_nxt = S_LOAD;
          else                            state_nxt = S_END;
        end
      end
      S_END:     if (!tx_busy) state_nxt = S_WAIT_HI;
      S_FIN:     state_nxt = S_FIN;
      default:   state_nxt = S_IDLE;
    endcase
    if (rx_finish) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      lfsr      <= SEED;
      shreg     <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      tx_seq    <= '0;
      term_sent <= 1'b0;
      for (int i = 0; i < NUM_SEQ; i++) tx_sum[i] <= '0;
    end else begin
      tx_start <= tx_fire;
      if (tx_fire) tx_byte <= (state == S_END) ? END_BYTE : shreg[WIDTH-1 -: 8];
      if (start_acc) begin
        lfsr      <= SEED;
        byte_idx  <= '0;
        word_idx  <= '0;
        tx_seq    <= '0;
        term_sent <= 1'b0;
        for (int i = 0; i < NUM_SEQ; i++) tx_sum[i] <= '0;
      end
      case (state)
        S_LOAD: begin
          shreg          <= lfsr[WIDTH-1:0];
          tx_sum[tx_seq] <= tx_sum[tx_seq] + SW'(lfsr[WIDTH-1:0]);
          lfsr           <= lfsr_step;
        end
        S_WAIT_LO: begin
          if (!tx_busy && !term_sent) begin
            if (!byte_last) begin
              byte_idx <= byte_idx + 1'b1;
              shreg    <= shreg << 8;
            end else begin
              byte_idx <= '0;
              if (!word_last) begin
                word_idx <= word_idx + 1'b1;
              end else begin
                word_idx <= '0;
                if (!seq_last) tx_seq <= tx_seq + 1'b1;
              end
            end
          end
        end
        S_END: if (tx_fire) term_sent <= 1'b1;
        default: ;
      endcase
    end
  end

  // Result checker: one word per NB bytes, verdict taken on the last word of a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      rx_shift  <= '0;
      prev_word <= '0;
      rx_bidx   <= '0;
      rx_widx   <= '0;
      rx_seq    <= '0;
      rx_sum    <= '0;
      seq_bad   <= 1'b0;
    end else if (start_acc) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      err_count <= '0;
      rx_shift  <= '0;
      prev_word <= '0;
      rx_bidx   <= '0;
      rx_widx   <= '0;
      rx_seq    <= '0;
      rx_sum    <= '0;
      seq_bad   <= 1'b0;
    end else if (rx_take) begin
      rx_shift <= rx_word;
      if (!word_end) begin
        rx_bidx <= rx_bidx + 1'b1;
      end else begin
        rx_bidx   <= '0;
        prev_word <= rx_word;
        if (!seq_end) begin
          rx_widx <= rx_widx + 1'b1;
          rx_sum  <= sum_now;
          seq_bad <= bad_now;
        end else begin
          rx_widx <= '0;
          rx_sum  <= '0;
          seq_bad <= 1'b0;
          if (seq_fail) err_count <= err_count + EW'(1);
          if (rx_finish) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            rx_seq <= '0;
          end else begin
            rx_seq <= rx_seq + 1'b1;
          end
        end
      end
    end
  end

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_uart_sort_host.sv
// Randomised self-checking bench for uart_sort_host with a small UART model and
// a reference model of the generated stream and the order/sum verdicts.
module tb_uart_sort_host;
  localparam int W = 8, D = 4, N = 2;
  localparam int NBYTES = N * D + 1;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       tx_busy = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_start, busy, done, pass;
  logic [1:0] err_count;

  uart_sort_host #(.WIDTH(W), .DEPTH(D), .NUM_SEQ(N), .END_BYTE(8'h0A), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: random pickup delay, then busy for 10 cycles.
  logic [7:0] cap_q [$];
  int  pulse_cnt = 0;
  bit  double_pulse = 0, unstable = 0;
  initial begin
    logic [7:0] hold;
    bit aborted;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        hold = tx_byte;
        aborted = 0;
        cap_q.push_back(hold);
        pulse_cnt++;
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (tx_start) double_pulse = 1;
        end
        tx_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1;
          if (tx_start && !aborted) double_pulse = 1;
          if (!aborted && tx_byte !== hold) unstable = 1;
        end
        tx_busy = 1'b0;
      end
    end
  end

  logic [7:0] exp_words [N*D];
  logic [7:0] ret [N*D];

  task automatic gen_expected();
    logic [31:0] r;
    r = SEED;
    for (int i = 0; i < N * D; i++) begin
      exp_words[i] = r[7:0];
      r = (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  // mode: 0 sorted, 1 adjacent swap, 2 last+1, 3 random shuffle, 4 random corrupt
  task automatic build_seq(input int s, input int mode);
    logic [7:0] a [D];
    logic [7:0] t;
    int j;
    for (int i = 0; i < D; i++) a[i] = exp_words[s*D + i];
    if (mode != 3) begin
      for (int p = 0; p < D - 1; p++)
        for (int q = 0; q < D - 1 - p; q++)
          if (a[q] > a[q+1]) begin t = a[q]; a[q] = a[q+1]; a[q+1] = t; end
    end
    case (mode)
      1: begin
        j = -1;
        for (int i = 0; i < D - 1; i++) if (j < 0 && a[i] != a[i+1]) j = i;
        if (j >= 0) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      end
      2: a[D-1] = a[D-1] + 8'd1;
      3: for (int i = D - 1; i > 0; i--) begin
           j = $urandom_range(0, i);
           t = a[i]; a[i] = a[j]; a[j] = t;
         end
      4: a[$urandom_range(0, D-1)] = 8'($urandom);
      default: ;
    endcase
    for (int i = 0; i < D; i++) ret[s*D + i] = a[i];
  endtask

  function automatic int model_err();
    int e = 0;
    for (int s = 0; s < N; s++) begin
      bit bad = 0;
      int got = 0, sent = 0;
      for (int w = 0; w < D; w++) begin
        if (w > 0 && ret[s*D + w] < ret[s*D + w - 1]) bad = 1;
        got  += ret[s*D + w];
        sent += exp_words[s*D + w];
      end
      if (got != sent) bad = 1;
      if (bad) e++;
    end
    return e;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int t = 0;
    while (cap_q.size() < n && t < 3000) begin @(posedge clk); t++; end
    if (t >= 3000) check_val({tag, "_timeout"}, cap_q.size(), n);
  endtask

  task automatic wait_uart_idle();
    int t = 0;
    while (tx_busy && t < 100) begin @(posedge clk); t++; end
  endtask

  task automatic send_results();
    for (int i = 0; i < N * D; i++) begin
      @(posedge clk); #1 rx_valid = 1'b1; rx_byte = ret[i];
      if (i != N * D - 1 && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1 rx_valid = 1'b0; rx_byte = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic full_run(input string tag, input int m0, input int m1, input bit poke_start);
    int e;
    cap_q.delete();
    pulse_start();
    if (poke_start) begin
      wait_bytes(4, {tag, "_mid"});
      pulse_start();
    end
    wait_bytes(NBYTES, tag);
    repeat (30) @(posedge clk);
    check_val({tag, "_nbytes"}, cap_q.size(), NBYTES);
    for (int i = 0; i < N * D && i < cap_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_words[i]);
    if (cap_q.size() >= NBYTES) check_val({tag, "_term"}, cap_q[NBYTES-1], 8'h0A);
    check_val({tag, "_busy_run"}, busy, 1'b1);
    wait_uart_idle();
    build_seq(0, m0);
    build_seq(1, m1);
    e = model_err();
    send_results();
    check_val({tag, "_done"}, done, 1'b1);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_err"}, err_count, e);
    check_val({tag, "_pass"}, pass, (e == 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [1:0] e_hold;
    gen_expected();
    check_val("model_first_byte", exp_words[0], 8'h34);

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); rx_valid = 1'($urandom); rx_byte = 8'($urandom);
      #7;
      check_val("rst_outputs", {tx_start, busy, done, pass, err_count, tx_byte}, 0);
    end
    start = 1'b0; rx_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1 rx_valid = 1'($urandom); rx_byte = 8'($urandom);
    end
    #1 rx_valid = 1'b0;
    check_val("idle_no_pulse", pulse_cnt, 0);
    check_val("idle_rx_ignored", {busy, done, err_count}, 0);

    full_run("loop", 0, 0, 1'b1);
    check_val("loop_err_zero", err_count, 0);
    check_val("loop_pass", pass, 1'b1);

    // strobes after done must not disturb anything
    p0 = pulse_cnt; e_hold = err_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 rx_valid = 1'b1; rx_byte = 8'($urandom);
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (5) @(posedge clk);
    check_val("post_done_hold", {done, busy, err_count}, {1'b1, 1'b0, e_hold});
    check_val("post_done_no_tx", pulse_cnt, p0);

    full_run("order", 1, 0, 1'b0);
    check_val("order_err_one", err_count, 1);
    full_run("sum", 2, 2, 1'b0);
    check_val("sum_err_two", err_count, 2);

    // abort during the 3rd byte
    cap_q.delete();
    pulse_start();
    wait_bytes(3, "abort");
    #2 rst_n = 1'b0;
    #1 check_val("abort_outputs", {tx_start, busy, done, pass, err_count, tx_byte}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_uart_idle();
    repeat (3) @(posedge clk);
    full_run("restart", 0, 0, 1'b0);

    for (int r = 0; r < 4; r++)
      full_run($sformatf("rnd%0d", r), $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));

    check_val("single_cycle_tx_start", double_pulse, 0);
    check_val("tx_byte_stable", unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
